// File: rtl/data_input_latch_if.sv
// Bus bundle between the 6502 external data pins, the internal bus
// multiplexers and the data input latch.
interface data_input_latch_if #(
   parameter int DATA_WIDTH  = 8,
   parameter int STALL_WIDTH = 8
);
   logic                   i_phi2;
   logic                   i_rw;
   logic                   i_rdy;
   logic                   i_sync;
   logic [DATA_WIDTH-1:0]  i_data;
   logic                   i_dl_db;
   logic                   i_dl_adl;
   logic                   i_dl_adh;
   logic [DATA_WIDTH-1:0]  o_dl;
   logic [DATA_WIDTH-1:0]  o_db;
   logic [DATA_WIDTH-1:0]  o_adl;
   logic [DATA_WIDTH-1:0]  o_adh;
   logic                   o_valid;
   logic [DATA_WIDTH-1:0]  o_opcode;
   logic                   o_opcode_valid;
   logic [STALL_WIDTH-1:0] o_stall_count;
   logic                   o_drive_conflict;

   modport master (
      output i_phi2, i_rw, i_rdy, i_sync, i_data,
      output i_dl_db, i_dl_adl, i_dl_adh,
      input  o_dl, o_db, o_adl, o_adh, o_valid,
      input  o_opcode, o_opcode_valid, o_stall_count,
      input  o_drive_conflict
   );

   modport slave (
      input  i_phi2, i_rw, i_rdy, i_sync, i_data,
      input  i_dl_db, i_dl_adl, i_dl_adh,
      output o_dl, o_db, o_adl, o_adh, o_valid,
      output o_opcode, o_opcode_valid, o_stall_count,
      output o_drive_conflict
   );
endinterface

// File: rtl/data_input_latch.sv
// 6502 read-path data latch: captures the bus on phi2 fall, preloads
// opcodes on SYNC, counts RDY stalls and gates DL onto DB/ADL/ADH.
module data_input_latch #(
   parameter int                    DATA_WIDTH  = 8,
   parameter int                    STALL_WIDTH = 8,
   parameter logic [DATA_WIDTH-1:0] IDLE_VALUE  = '0
) (
   input logic                i_clk,
   input logic                i_reset,
   data_input_latch_if.slave  bus
);
   logic                   r_phi2_q;
   logic [DATA_WIDTH-1:0]  r_sample;
   logic [DATA_WIDTH-1:0]  r_dl;
   logic [DATA_WIDTH-1:0]  r_opcode;
   logic                   r_valid;
   logic                   r_opcode_valid;
   logic [STALL_WIDTH-1:0] r_stall;

   logic w_fall;
   logic w_conflict;

   assign w_fall     = r_phi2_q & ~bus.i_phi2;
   assign w_conflict = bus.i_dl_adl & bus.i_dl_adh;

   // r_sample holds the bus from the last phi2-high clock, so the
   // commit needs no hold time after phi2 falls.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_phi2_q       <= 1'b0;
         r_sample       <= '0;
         r_dl           <= '0;
         r_opcode       <= '0;
         r_valid        <= 1'b0;
         r_opcode_valid <= 1'b0;
         r_stall        <= '0;
      end else begin
         r_phi2_q       <= bus.i_phi2;
         r_valid        <= 1'b0;
         r_opcode_valid <= 1'b0;
         if (bus.i_phi2)
            r_sample <= bus.i_data;
         if (w_fall && bus.i_rw) begin
            r_dl <= r_sample;
            if (bus.i_rdy) begin
               r_valid <= 1'b1;
               r_stall <= '0;
               if (bus.i_sync) begin
                  r_opcode       <= r_sample;
                  r_opcode_valid <= 1'b1;
               end
            end else if (r_stall != '1) begin
               r_stall <= r_stall + 1'b1;
            end
         end
      end
   end

   assign bus.o_dl             = r_dl;
   assign bus.o_valid          = r_valid;
   assign bus.o_opcode         = r_opcode;
   assign bus.o_opcode_valid   = r_opcode_valid;
   assign bus.o_stall_count    = r_stall;
   assign bus.o_drive_conflict = w_conflict;

   assign bus.o_db  = bus.i_dl_db ? r_dl : IDLE_VALUE;
   assign bus.o_adl = (bus.i_dl_adl && !w_conflict) ? r_dl : IDLE_VALUE;
   assign bus.o_adh = (bus.i_dl_adh && !w_conflict) ? r_dl : IDLE_VALUE;
endmodule

// File: tb/tb_data_input_latch.sv
// Self-checking bench for data_input_latch: directed scenarios plus a
// randomized run against a bus-cycle level reference model.
module tb_data_input_latch;
   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   data_input_latch_if bus ();

   data_input_latch dut (
      .i_clk   (clk),
      .i_reset (rst),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // one phi2-high clock with d on the bus, then the falling-edge clock
   task automatic bus_cycle(input logic [7:0] d, input logic rw,
                            input logic rdy, input logic sync);
      bus.i_phi2 = 1'b1;
      bus.i_data = d;
      tick();
      bus.i_phi2 = 1'b0;
      bus.i_rw   = rw;
      bus.i_rdy  = rdy;
      bus.i_sync = sync;
      tick();
      bus.i_rw   = 1'b1;
      bus.i_rdy  = 1'b1;
      bus.i_sync = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.i_phi2 = 1'b1;
      bus.i_data = 8'hA5;
      tick();
      tick();
      n_checks++;
      if (bus.o_dl !== 8'h00) begin
         n_fail++; $display("FAIL reset_dl got=%h exp=00", bus.o_dl);
      end
      n_checks++;
      if (bus.o_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_valid got=%b exp=0", bus.o_valid);
      end
      n_checks++;
      if (bus.o_stall_count !== 8'd0) begin
         n_fail++; $display("FAIL reset_stall got=%0d exp=0", bus.o_stall_count);
      end
      rst = 1'b0;
      tick();
      bus.i_phi2 = 1'b0;
      tick();
      n_checks++;
      if (bus.o_dl !== 8'hA5 || bus.o_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL first_commit got=%h/%b exp=a5/1", bus.o_dl, bus.o_valid);
      end
   endtask

   task automatic test_read_commit();
      logic [7:0] seq [3];
      seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h3C;
      bus.i_phi2 = 1'b1;
      for (int k = 0; k < 3; k++) begin
         bus.i_data = seq[k];
         tick();
      end
      bus.i_data = 8'h99;
      bus.i_phi2 = 1'b0;
      tick();
      n_checks++;
      if (bus.o_dl !== 8'h3C || bus.o_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL read_commit got=%h/%b exp=3c/1", bus.o_dl, bus.o_valid);
      end
      tick();
      n_checks++;
      if (bus.o_valid !== 1'b0) begin
         n_fail++; $display("FAIL valid_pulse got=%b exp=0", bus.o_valid);
      end
   endtask

   task automatic test_opcode_fetch();
      bus_cycle(8'hA9, 1'b1, 1'b1, 1'b1);
      n_checks++;
      if (bus.o_opcode !== 8'hA9 || bus.o_opcode_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL opcode got=%h/%b exp=a9/1", bus.o_opcode,
                  bus.o_opcode_valid);
      end
      tick();
      n_checks++;
      if (bus.o_opcode_valid !== 1'b0) begin
         n_fail++; $display("FAIL opcode_pulse got=%b exp=0", bus.o_opcode_valid);
      end
      bus_cycle(8'h42, 1'b1, 1'b1, 1'b0);
      n_checks++;
      if (bus.o_opcode !== 8'hA9 || bus.o_opcode_valid !== 1'b0 ||
          bus.o_dl !== 8'h42) begin
         n_fail++;
         $display("FAIL opcode_hold got=%h/%b/%h exp=a9/0/42", bus.o_opcode,
                  bus.o_opcode_valid, bus.o_dl);
      end
   endtask

   task automatic test_stall_saturation();
      bit seen_valid;
      seen_valid = 1'b0;
      for (int k = 0; k < 300; k++) begin
         bus_cycle(k[7:0], 1'b1, 1'b0, 1'b0);
         if (bus.o_valid !== 1'b0) seen_valid = 1'b1;
      end
      n_checks++;
      if (bus.o_stall_count !== 8'd255) begin
         n_fail++; $display("FAIL stall_sat got=%0d exp=255", bus.o_stall_count);
      end
      n_checks++;
      if (seen_valid) begin
         n_fail++; $display("FAIL stall_valid got=1 exp=0");
      end
      bus_cycle(8'h77, 1'b1, 1'b1, 1'b0);
      n_checks++;
      if (bus.o_stall_count !== 8'd0 || bus.o_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL stall_clear got=%0d/%b exp=0/1", bus.o_stall_count,
                  bus.o_valid);
      end
   endtask

   task automatic test_write();
      bus_cycle(8'h3C, 1'b1, 1'b1, 1'b0);
      tick();
      bus_cycle(8'hFF, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (bus.o_dl !== 8'h3C || bus.o_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL write got=%h/%b exp=3c/0", bus.o_dl, bus.o_valid);
      end
   endtask

   task automatic test_bus_drive();
      bus_cycle(8'h5A, 1'b1, 1'b1, 1'b0);
      bus.i_dl_db  = 1'b1;
      bus.i_dl_adl = 1'b1;
      #1;
      n_checks++;
      if (bus.o_db !== 8'h5A || bus.o_adl !== 8'h5A || bus.o_adh !== 8'h00 ||
          bus.o_drive_conflict !== 1'b0) begin
         n_fail++;
         $display("FAIL drive got=%h/%h/%h/%b exp=5a/5a/00/0", bus.o_db,
                  bus.o_adl, bus.o_adh, bus.o_drive_conflict);
      end
      bus.i_dl_adh = 1'b1;
      #1;
      n_checks++;
      if (bus.o_db !== 8'h5A || bus.o_adl !== 8'h00 || bus.o_adh !== 8'h00 ||
          bus.o_drive_conflict !== 1'b1) begin
         n_fail++;
         $display("FAIL conflict got=%h/%h/%h/%b exp=5a/00/00/1", bus.o_db,
                  bus.o_adl, bus.o_adh, bus.o_drive_conflict);
      end
      bus.i_dl_db  = 1'b0;
      bus.i_dl_adl = 1'b0;
      bus.i_dl_adh = 1'b0;
   endtask

   task automatic test_reset_on_edge();
      bus.i_phi2 = 1'b1;
      bus.i_data = 8'h77;
      tick();
      bus.i_phi2 = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_checks++;
      if (bus.o_dl !== 8'h00 || bus.o_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_edge got=%h/%b exp=00/0", bus.o_dl, bus.o_valid);
      end
   endtask

   task automatic test_random();
      logic [7:0] m_dl, m_op, d, exp_adl, exp_adh;
      int         m_stall, nhigh;
      logic       rw, rdy, sync, exp_v, exp_ov, db, adl, adh;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      m_dl = 8'h00; m_op = 8'h00; m_stall = 0;
      for (int it = 0; it < 200; it++) begin
         nhigh = $urandom_range(1, 3);
         bus.i_phi2 = 1'b1;
         for (int k = 0; k < nhigh; k++) begin
            d = 8'($urandom);
            bus.i_data = d;
            tick();
            n_checks++;
            if (bus.o_valid !== 1'b0 || bus.o_opcode_valid !== 1'b0) begin
               n_fail++;
               $display("FAIL rnd_idle it=%0d got=%b/%b exp=0/0", it,
                        bus.o_valid, bus.o_opcode_valid);
            end
         end
         rw   = ($urandom_range(0, 3) != 0);
         rdy  = ($urandom_range(0, 3) != 0);
         sync = $urandom_range(0, 1) == 1;
         bus.i_phi2 = 1'b0;
         bus.i_data = 8'($urandom);
         bus.i_rw   = rw;
         bus.i_rdy  = rdy;
         bus.i_sync = sync;
         tick();
         exp_v  = rw && rdy;
         exp_ov = rw && rdy && sync;
         if (rw) m_dl = d;
         if (exp_ov) m_op = d;
         if (rw && rdy) m_stall = 0;
         else if (rw) m_stall = (m_stall >= 255) ? 255 : m_stall + 1;
         db  = $urandom_range(0, 1) == 1;
         adl = $urandom_range(0, 1) == 1;
         adh = $urandom_range(0, 1) == 1;
         bus.i_dl_db  = db;
         bus.i_dl_adl = adl;
         bus.i_dl_adh = adh;
         #1;
         exp_adl = (adl && !adh) ? m_dl : 8'h00;
         exp_adh = (adh && !adl) ? m_dl : 8'h00;
         n_checks++;
         if (bus.o_dl !== m_dl || bus.o_valid !== exp_v ||
             bus.o_opcode !== m_op || bus.o_opcode_valid !== exp_ov ||
             bus.o_stall_count !== 8'(m_stall)) begin
            n_fail++;
            $display("FAIL rnd_commit it=%0d got=%h/%b/%h/%b/%0d exp=%h/%b/%h/%b/%0d",
                     it, bus.o_dl, bus.o_valid, bus.o_opcode,
                     bus.o_opcode_valid, bus.o_stall_count, m_dl, exp_v,
                     m_op, exp_ov, m_stall);
         end
         n_checks++;
         if (bus.o_db !== (db ? m_dl : 8'h00) || bus.o_adl !== exp_adl ||
             bus.o_adh !== exp_adh || bus.o_drive_conflict !== (adl && adh)) begin
            n_fail++;
            $display("FAIL rnd_drive it=%0d got=%h/%h/%h/%b", it, bus.o_db,
                     bus.o_adl, bus.o_adh, bus.o_drive_conflict);
         end
         bus.i_rw   = 1'b1;
         bus.i_rdy  = 1'b1;
         bus.i_sync = 1'b0;
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst = 1'b1;
      bus.i_phi2   = 1'b0;
      bus.i_rw     = 1'b1;
      bus.i_rdy    = 1'b1;
      bus.i_sync   = 1'b0;
      bus.i_data   = 8'h00;
      bus.i_dl_db  = 1'b0;
      bus.i_dl_adl = 1'b0;
      bus.i_dl_adh = 1'b0;
      test_reset();
      test_read_commit();
      test_opcode_fetch();
      test_stall_saturation();
      test_write();
      test_bus_drive();
      test_reset_on_edge();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/data_input_latch.md
Name: data_input_latch

Overview:
CPU-side input path for the 6502 core: captures the external data bus at the end of each read cycle (phi2 falling edge) into the Data Latch (DL). It gates DL onto the internal DB, ADL and ADH buses. It also preloads the fetched opcode on SYNC cycles and counts RDY stall cycles. It is the read-direction counterpart of the data output register, and sits between the external data pins and the internal bus multiplexers.

Parameters:
DATA_WIDTH, 8, width of external data bus and DL
STALL_WIDTH, 8, width of saturating RDY stall counter
IDLE_VALUE, 8'h00, value on an internal bus output when DL is not driving it

Ports:
i_clk  input  1  system clock; all state updates on rising edge
i_reset  input  1  synchronous reset, active-high
i_phi2  input  1  phase level sampled each clock; 1 = phi2 (bus data phase)
i_rw  input  1  external read/write pin (read = HIGH, write = LOW)
i_rdy  input  1  RDY pin; 0 = read cycle stalled
i_sync  input  1  current cycle is an opcode fetch
i_data  input  DATA_WIDTH  external data bus
i_dl_db  input  1  drive DL onto DB
i_dl_adl  input  1  drive DL onto ADL
i_dl_adh  input  1  drive DL onto ADH
o_dl  output  DATA_WIDTH  current DL contents
o_db  output  DATA_WIDTH  DL or IDLE_VALUE
o_adl  output  DATA_WIDTH  DL or IDLE_VALUE
o_adh  output  DATA_WIDTH  DL or IDLE_VALUE
o_valid  output  1  one-cycle pulse: DL updated by a completed read
o_opcode  output  DATA_WIDTH  last fetched opcode
o_opcode_valid  output  1  one-cycle pulse: o_opcode updated
o_stall_count  output  STALL_WIDTH  consecutive stalled read cycles, saturating
o_drive_conflict  output  1  i_dl_adl and i_dl_adh both asserted

Behaviour:
- Reset (synchronous, has priority over every other update, including a commit in the same cycle): DL=0, sample=0, phi2_q=0, o_opcode=0, o_valid=0, o_opcode_valid=0, o_stall_count=0.
- phi2_q: register of i_phi2. Falling edge = phi2_q & !i_phi2. phi2_q=0 after reset, so no spurious edge occurs on the first cycle.
- Sample register: loads i_data on every clock where i_phi2=1; holds otherwise. The value committed is the bus as seen on the last phi2-high clock, so there is no hold requirement after phi2 falls.
- Commit on a falling-edge cycle, with i_rw/i_rdy/i_sync sampled in that same cycle:
  - i_rw=1, i_rdy=1: DL<=sample; o_valid=1 next cycle; o_stall_count<=0. If also i_sync=1: o_opcode<=sample and o_opcode_valid=1 next cycle.
  - i_rw=1, i_rdy=0: DL<=sample (bus tracking); o_valid stays 0; no opcode update; o_stall_count increments, saturating at all-ones.
  - i_rw=0 (write): no change to DL, opcode or stall count; o_valid=0. RDY is ignored on writes.
- Latency: commit in cycle N; o_dl, o_valid and o_opcode are visible in cycle N+1. o_valid and o_opcode_valid deassert in N+2 unless another edge occurs.
- Bus outputs are combinational from the registered DL:
  - o_db = i_dl_db ? DL : IDLE_VALUE.
  - o_adl and o_adh follow the same rule, except when i_dl_adl & i_dl_adh are both high: then both are IDLE_VALUE and o_drive_conflict=1.
  - DB may be driven together with ADL or ADH with no conflict.
- No edge and no reset: all registers hold.

Test Plan:
- Reset then idle: i_reset=1 for 2 clocks with i_phi2=1, i_data=8'hA5 -> o_dl=0, o_valid=0, o_stall_count=0. The first falling edge after reset commits 8'hA5.
- Read commit: i_phi2 high for 3 clocks (i_data 8'h11, 8'h22, 8'h3C), then low, i_rw=1, i_rdy=1 -> o_dl=8'h3C and one-cycle o_valid on the next clock.
- Opcode fetch: same sequence with i_sync=1 and i_data=8'hA9 -> o_opcode=8'hA9, o_opcode_valid pulses once. A following read with i_sync=0 and data 8'h42 leaves o_opcode=8'hA9.
- Stall and saturation: 300 consecutive read cycles with i_rdy=0 -> o_stall_count=255 and o_valid never asserts. The next read with i_rdy=1 -> o_stall_count=0 and o_valid pulses.
- Write cycle: DL=8'h3C, then a cycle with i_rw=0 and i_data=8'hFF -> o_dl stays 8'h3C, no o_valid.
- Bus drive: DL=8'h5A, i_dl_db=1 and i_dl_adl=1 -> o_db=o_adl=8'h5A, o_adh=0. Then i_dl_adl=i_dl_adh=1 -> o_adl=o_adh=0 and o_drive_conflict=1. Reset asserted on a falling-edge cycle -> o_dl=0.
